// File: rtl/apu_cluster_package.sv
// Shared constants and operand types for the APU cluster's shared fp units.
package apu_cluster_package;

  localparam int unsigned FP_WIDTH        = 32;
  localparam int unsigned NDSFLAGS_ADDSUB = 3;
  localparam int unsigned NUSFLAGS_ADDSUB = 5;

  // Operand bundle of one add/sub operation; the unit tag is appended by
  // each arbiter because its width depends on that arbiter's parameters.
  typedef struct packed {
    logic                       subsel;
    logic [FP_WIDTH-1:0]        opa;
    logic [FP_WIDTH-1:0]        opb;
    logic [NDSFLAGS_ADDSUB-1:0] rnd;
  } fp_addsub_op_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// Issue/result bus between the add/sub arbiter (master) and the shared fp unit (slave).
interface fp_addsub_arbiter_if #(
  parameter int unsigned TAG_WIDTH = 4
) ();
  import apu_cluster_package::*;

  logic                       UnitEn_o;
  logic                       UnitSubSel_o;
  logic [FP_WIDTH-1:0]        UnitOpA_o;
  logic [FP_WIDTH-1:0]        UnitOpB_o;
  logic [NDSFLAGS_ADDSUB-1:0] UnitRnd_o;
  logic [TAG_WIDTH-1:0]       UnitTag_o;
  logic                       UnitReady_i;
  logic                       UnitValid_i;
  logic [FP_WIDTH-1:0]        UnitRes_i;
  logic [NUSFLAGS_ADDSUB-1:0] UnitStatus_i;
  logic [TAG_WIDTH-1:0]       UnitTag_i;

  modport master (
    output UnitEn_o, UnitSubSel_o, UnitOpA_o, UnitOpB_o, UnitRnd_o, UnitTag_o,
    input  UnitReady_i, UnitValid_i, UnitRes_i, UnitStatus_i, UnitTag_i
  );

  modport slave (
    input  UnitEn_o, UnitSubSel_o, UnitOpA_o, UnitOpB_o, UnitRnd_o, UnitTag_o,
    output UnitReady_i, UnitValid_i, UnitRes_i, UnitStatus_i, UnitTag_i
  );

endinterface

// File: rtl/rr_arb_tree_lite.sv
// Round-robin arbiter: scans upward from i_ptr+1 with wrap, one-hot grant plus winner index.
module rr_arb_tree_lite #(
  parameter  int unsigned N   = 4,
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  always_comb begin
    int unsigned k;
    o_gnt = '0;
    o_idx = i_ptr;
    o_any = 1'b0;
    k     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = (32'(i_ptr) + i) % N;
      if (!o_any && i_req[k]) begin
        o_any    = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one pipelined fp add/sub unit between NB_REQ requesters, routing results by tag ID.
// Optional stall counters per requester under `define FP_ADDSUB_ARB_PERF_EN.
module fp_addsub_arbiter
  import apu_cluster_package::*;
#(
  parameter  int unsigned NB_REQ         = 4,
  parameter  int unsigned USER_TAG_WIDTH = 2,
  parameter  int unsigned MAX_INFLIGHT   = 8,
  localparam int unsigned ID_WIDTH       = id_width(NB_REQ),
  localparam int unsigned UNIT_TAG_WIDTH = ID_WIDTH + USER_TAG_WIDTH
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NB_REQ-1:0]                        Req_i,
  output logic [NB_REQ-1:0]                        Gnt_o,
  input  logic [NB_REQ-1:0]                        SubSel_i,
  input  logic [NB_REQ-1:0][FP_WIDTH-1:0]          OpA_i,
  input  logic [NB_REQ-1:0][FP_WIDTH-1:0]          OpB_i,
  input  logic [NB_REQ-1:0][NDSFLAGS_ADDSUB-1:0]   Rnd_i,
  input  logic [NB_REQ-1:0][USER_TAG_WIDTH-1:0]    Tag_i,
  output logic [NB_REQ-1:0]                        Valid_o,
  output logic [FP_WIDTH-1:0]                      Res_o,
  output logic [NUSFLAGS_ADDSUB-1:0]               Status_o,
  output logic [USER_TAG_WIDTH-1:0]                TagOut_o,
  fp_addsub_arbiter_if.master                      unit,
  output logic                                     Busy_o
`ifdef FP_ADDSUB_ARB_PERF_EN
  ,
  input  logic                                     PerfClr_i,
  output logic [NB_REQ-1:0][31:0]                  PerfStall_o
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  // Tag width depends on NB_REQ/USER_TAG_WIDTH, so the full issue record is typed here.
  typedef struct packed {
    fp_addsub_op_t             op;
    logic [UNIT_TAG_WIDTH-1:0] tag;
  } fp_addsub_req_t;

  logic [ID_WIDTH-1:0]        r_ptr;
  logic [ID_WIDTH-1:0]        w_idx;
  logic                       w_xfer;
  logic                       w_can_grant;
  logic [NB_REQ-1:0]          w_req;
  logic                       r_issue_en;
  fp_addsub_req_t             r_issue;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_rvalid;
  logic [ID_WIDTH-1:0]        r_rid;
  logic [FP_WIDTH-1:0]        r_res;
  logic [NUSFLAGS_ADDSUB-1:0] r_status;
  logic [USER_TAG_WIDTH-1:0]  r_utag;

  // Registered count already includes last cycle's issue, so a full count blocks at once.
  assign w_can_grant = !rst_i && unit.UnitReady_i && (r_cnt < CNT_W'(MAX_INFLIGHT));
  assign w_req       = w_can_grant ? Req_i : '0;

  rr_arb_tree_lite #(
    .N (NB_REQ)
  ) u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (Gnt_o),
    .o_idx (w_idx),
    .o_any (w_xfer)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr      <= ID_WIDTH'(NB_REQ - 1);
      r_issue_en <= 1'b0;
      r_issue    <= '0;
    end else begin
      r_issue_en <= w_xfer;
      if (w_xfer) begin
        r_ptr             <= w_idx;
        r_issue.op.subsel <= SubSel_i[w_idx];
        r_issue.op.opa    <= OpA_i[w_idx];
        r_issue.op.opb    <= OpB_i[w_idx];
        r_issue.op.rnd    <= Rnd_i[w_idx];
        r_issue.tag       <= {w_idx, Tag_i[w_idx]};
      end
    end
  end

  assign unit.UnitEn_o     = r_issue_en;
  assign unit.UnitSubSel_o = r_issue.op.subsel;
  assign unit.UnitOpA_o    = r_issue.op.opa;
  assign unit.UnitOpB_o    = r_issue.op.opb;
  assign unit.UnitRnd_o    = r_issue.op.rnd;
  assign unit.UnitTag_o    = r_issue.tag;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_res    <= '0;
      r_status <= '0;
      r_utag   <= '0;
    end else begin
      r_rvalid <= unit.UnitValid_i;
      if (unit.UnitValid_i) begin
        r_rid    <= unit.UnitTag_i[UNIT_TAG_WIDTH-1 -: ID_WIDTH];
        r_res    <= unit.UnitRes_i;
        r_status <= unit.UnitStatus_i;
        r_utag   <= unit.UnitTag_i[USER_TAG_WIDTH-1:0];
      end
    end
  end

  // Out-of-range IDs raise no Valid_o but still retire from the in-flight count below.
  always_comb begin
    Valid_o = '0;
    if (r_rvalid && (32'(r_rid) < NB_REQ)) begin
      Valid_o[r_rid] = 1'b1;
    end
  end

  assign Res_o    = r_res;
  assign Status_o = r_status;
  assign TagOut_o = r_utag;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_xfer, r_rvalid})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign Busy_o = r_issue_en || (r_cnt != '0);

`ifdef FP_ADDSUB_ARB_PERF_EN
  logic [NB_REQ-1:0][31:0] r_perf;

  always_ff @(posedge clk_i) begin
    if (rst_i || PerfClr_i) begin
      r_perf <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_REQ; i++) begin
        if (Req_i[i] && !Gnt_o[i]) begin
          r_perf[i] <= r_perf[i] + 32'd1;
        end
      end
    end
  end

  assign PerfStall_o = r_perf;
`endif

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench: dut1 (defaults, modelled unit) and dut2 (3 requesters, MAX_INFLIGHT=2, hand-driven unit).
module tb_fp_addsub_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  // dut1 stimulus
  logic [3:0]       req1;
  logic [3:0]       sub1;
  logic [3:0][31:0] opa1;
  logic [3:0][31:0] opb1;
  logic [3:0][2:0]  rnd1;
  logic [3:0][1:0]  tag1;
  logic [3:0]       gnt1;
  logic [3:0]       valid1;
  logic [31:0]      res1;
  logic [4:0]       status1;
  logic [1:0]       tagout1;
  logic             busy1;
  logic             ready1;
  int               lat;

  // dut2 stimulus
  logic [2:0]       req2;
  logic [2:0]       gnt2;
  logic [2:0]       valid2;
  logic [31:0]      res2;
  logic [4:0]       status2;
  logic [1:0]       tagout2;
  logic             busy2;
  logic             v2valid;
  logic [3:0]       v2tag;
  logic [31:0]      v2res;

`ifdef FP_ADDSUB_ARB_PERF_EN
  logic             clr1;
  logic [3:0][31:0] perf1;
  logic [2:0][31:0] perf2;
`endif

  fp_addsub_arbiter_if #(.TAG_WIDTH(4)) u_if1 ();
  fp_addsub_arbiter_if #(.TAG_WIDTH(4)) u_if2 ();

  fp_addsub_arbiter #(
    .NB_REQ(4), .USER_TAG_WIDTH(2), .MAX_INFLIGHT(8)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .Req_i(req1), .Gnt_o(gnt1), .SubSel_i(sub1),
    .OpA_i(opa1), .OpB_i(opb1), .Rnd_i(rnd1), .Tag_i(tag1), .Valid_o(valid1),
    .Res_o(res1), .Status_o(status1), .TagOut_o(tagout1), .unit(u_if1.master),
    .Busy_o(busy1)
`ifdef FP_ADDSUB_ARB_PERF_EN
    , .PerfClr_i(clr1), .PerfStall_o(perf1)
`endif
  );

  fp_addsub_arbiter #(
    .NB_REQ(3), .USER_TAG_WIDTH(2), .MAX_INFLIGHT(2)
  ) u_dut2 (
    .clk_i(clk), .rst_i(rst), .Req_i(req2), .Gnt_o(gnt2), .SubSel_i(3'b000),
    .OpA_i('0), .OpB_i('0), .Rnd_i('0), .Tag_i('0), .Valid_o(valid2),
    .Res_o(res2), .Status_o(status2), .TagOut_o(tagout2), .unit(u_if2.master),
    .Busy_o(busy2)
`ifdef FP_ADDSUB_ARB_PERF_EN
    , .PerfClr_i(1'b0), .PerfStall_o(perf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency stand-in for the fp unit, answering from a table of hand-computed sums.
  function automatic logic [31:0] fp_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    case ({s, a, b})
      {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
      default:                            return 32'h7FC00000;
    endcase
  endfunction

  logic        p_v   [0:7];
  logic [31:0] p_res [0:7];
  logic [4:0]  p_st  [0:7];
  logic [3:0]  p_tag [0:7];

  always @(posedge clk) begin
    p_v[0]   <= u_if1.UnitEn_o && u_if1.UnitReady_i;
    p_res[0] <= fp_model(u_if1.UnitSubSel_o, u_if1.UnitOpA_o, u_if1.UnitOpB_o);
    p_st[0]  <= {2'b00, u_if1.UnitRnd_o};
    p_tag[0] <= u_if1.UnitTag_o;
    for (int k = 1; k < 8; k++) begin
      p_v[k]   <= p_v[k-1];
      p_res[k] <= p_res[k-1];
      p_st[k]  <= p_st[k-1];
      p_tag[k] <= p_tag[k-1];
    end
  end

  assign u_if1.UnitReady_i  = ready1;
  assign u_if1.UnitValid_i  = p_v[lat-1];
  assign u_if1.UnitRes_i    = p_res[lat-1];
  assign u_if1.UnitStatus_i = p_st[lat-1];
  assign u_if1.UnitTag_i    = p_tag[lat-1];

  assign u_if2.UnitReady_i  = 1'b1;
  assign u_if2.UnitValid_i  = v2valid;
  assign u_if2.UnitRes_i    = v2res;
  assign u_if2.UnitStatus_i = 5'd0;
  assign u_if2.UnitTag_i    = v2tag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    rst = 1'b1; lat = 2; ready1 = 1'b1;
    req1 = '0; sub1 = '0; opa1 = '0; opb1 = '0; rnd1 = '0; tag1 = '0;
    req2 = '0; v2valid = 1'b0; v2tag = '0; v2res = '0;
`ifdef FP_ADDSUB_ARB_PERF_EN
    clr1 = 1'b0;
`endif
    repeat (3) cyc();
    #1;
    chk("rst_gnt",   64'(gnt1),            64'(0));
    chk("rst_valid", 64'(valid1),          64'(0));
    chk("rst_en",    64'(u_if1.UnitEn_o),  64'(0));
    chk("rst_res",   64'(res1),            64'(0));
    chk("rst_busy",  64'(busy1),           64'(0));
    chk("rst_busy2", 64'(busy2),           64'(0));
    rst = 1'b0;

    // single requester 1.0 + 2.0, unit latency 2
    cyc();
    req1 = 4'b0001; opa1[0] = 32'h3F800000; opb1[0] = 32'h40000000; rnd1[0] = 3'd1; tag1[0] = 2'b10;
    #1 chk("t1_gnt", 64'(gnt1), 64'(4'b0001));
    cyc(); req1 = '0;
    #1;
    chk("t1_en",   64'(u_if1.UnitEn_o),  64'(1));
    chk("t1_utag", 64'(u_if1.UnitTag_o), 64'(4'b0010));
    chk("t1_opa",  64'(u_if1.UnitOpA_o), 64'(32'h3F800000));
    chk("t1_opb",  64'(u_if1.UnitOpB_o), 64'(32'h40000000));
    chk("t1_busy", 64'(busy1),           64'(1));
    cyc(); #1 chk("t1_v2", 64'(valid1), 64'(0));
    cyc(); #1 chk("t1_v3", 64'(valid1), 64'(0));
    cyc(); #1;
    chk("t1_valid",  64'(valid1),  64'(4'b0001));
    chk("t1_res",    64'(res1),    64'(32'h40400000));
    chk("t1_status", 64'(status1), 64'(5'd1));
    chk("t1_tagout", 64'(tagout1), 64'(2'b10));
    cyc(); #1;
    chk("t1_idle_busy",  64'(busy1),  64'(0));
    chk("t1_idle_valid", 64'(valid1), 64'(0));

    // unit not ready for 3 cycles
    cyc();
    ready1 = 1'b0; req1 = 4'b0100;
    sub1[2] = 1'b1; opa1[2] = 32'h40400000; opb1[2] = 32'h3F800000; rnd1[2] = 3'd2; tag1[2] = 2'd1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      #1 chk("t4_stall_gnt", 64'(gnt1), 64'(0));
    end
    cyc(); ready1 = 1'b1;
    #1 chk("t4_gnt", 64'(gnt1), 64'(4'b0100));
    cyc(); req1 = '0;
    #1;
    chk("t4_sub",  64'(u_if1.UnitSubSel_o), 64'(1));
    chk("t4_opa",  64'(u_if1.UnitOpA_o),    64'(32'h40400000));
    chk("t4_opb",  64'(u_if1.UnitOpB_o),    64'(32'h3F800000));
    chk("t4_utag", 64'(u_if1.UnitTag_o),    64'(4'b1001));
    repeat (3) cyc();
    #1;
    chk("t4_valid",  64'(valid1),  64'(4'b0100));
    chk("t4_res",    64'(res1),    64'(32'h40000000));
    chk("t4_status", 64'(status1), 64'(5'd2));
    chk("t4_tagout", 64'(tagout1), 64'(2'd1));

    // reset with three ops in flight, unit latency 5
    lat = 5;
    for (int i = 0; i < 4; i++) begin
      sub1[i] = 1'b0; opa1[i] = 32'h3F800000; opb1[i] = 32'h3F800000; rnd1[i] = 3'd0; tag1[i] = 2'(i);
    end
    cyc(); req1 = 4'b0111;
    #1 chk("t5_gnt0", 64'(gnt1), 64'(4'b0001));
    cyc(); #1 chk("t5_gnt1", 64'(gnt1), 64'(4'b0010));
    cyc(); #1 chk("t5_gnt2", 64'(gnt1), 64'(4'b0100));
    cyc(); req1 = '0; rst = 1'b1;
    #1 chk("t5_busy_pre", 64'(busy1), 64'(1));
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      chk("t5_rst_valid", 64'(valid1), 64'(0));
      if (i == 0) begin
        chk("t5_rst_en",   64'(u_if1.UnitEn_o), 64'(0));
        chk("t5_rst_busy", 64'(busy1),          64'(0));
        chk("t5_rst_res",  64'(res1),           64'(0));
      end
    end
    rst = 1'b0; lat = 2;
    cyc(); #1;
    chk("t5_after_busy",  64'(busy1),  64'(0));
    chk("t5_after_valid", 64'(valid1), 64'(0));

    // all four requesting continuously from reset pointer
    for (int j = 0; j < 9; j++) begin
      if (j > 0) cyc();
      req1 = (j < 5) ? 4'b1111 : 4'b0000;
      #1;
      chk("t2_gnt", 64'(gnt1), (j < 5) ? 64'(4'b0001 << (j % 4)) : 64'(0));
      if (j >= 4) begin
        chk("t2_valid",  64'(valid1),  64'(4'b0001 << ((j - 4) % 4)));
        chk("t2_tagout", 64'(tagout1), 64'((j - 4) % 4));
        chk("t2_res",    64'(res1),    64'(32'h40000000));
      end
    end

    // dut2: MAX_INFLIGHT=2 throttling and out-of-range result ID
    cyc(); req2 = 3'b111;
    #1 chk("m_gnt0", 64'(gnt2), 64'(3'b001));
    cyc(); #1 chk("m_gnt1", 64'(gnt2), 64'(3'b010));
    cyc(); #1;
    chk("m_full_gnt", 64'(gnt2),  64'(0));
    chk("m_busy",     64'(busy2), 64'(1));
    cyc(); #1 chk("m_full_gnt2", 64'(gnt2), 64'(0));
    v2valid = 1'b1; v2tag = 4'b0000; v2res = 32'h12345678;
    cyc(); v2valid = 1'b0;
    #1;
    chk("m_valid",   64'(valid2), 64'(3'b001));
    chk("m_res",     64'(res2),   64'(32'h12345678));
    chk("m_samecyc", 64'(gnt2),   64'(0));
    cyc(); #1 chk("m_freed_gnt", 64'(gnt2), 64'(3'b100));
    cyc(); #1;
    chk("m_full_gnt3", 64'(gnt2),  64'(0));
    chk("m_busy2",     64'(busy2), 64'(1));
    v2valid = 1'b1; v2tag = 4'b1100;
    cyc(); v2valid = 1'b0;
    #1;
    chk("m_oor_valid", 64'(valid2), 64'(0));
    chk("m_oor_gnt",   64'(gnt2),   64'(0));
    cyc(); #1 chk("m_oor_freed", 64'(gnt2), 64'(3'b001));
    req2 = '0;

`ifdef FP_ADDSUB_ARB_PERF_EN
    cyc(); clr1 = 1'b1; req1 = '0;
    cyc(); clr1 = 1'b0; req1 = 4'b1000; ready1 = 1'b0;
    repeat (4) cyc();
    cyc(); #1;
    chk("perf_stall3", 64'(perf1[3]), 64'(5));
    chk("perf_stall0", 64'(perf1[0]), 64'(0));
    clr1 = 1'b1;
    cyc(); clr1 = 1'b0; req1 = '0; ready1 = 1'b1;
    #1 chk("perf_clr", 64'(perf1[3]), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
